// File: rtl/soc_pio_pkg.sv
// ---------------------------------------------------------------------------
// soc_pio_pkg
// Shared constants for the Avalon-MM parallel I/O slaves on the lightweight
// HPS bridge. It contains the register word addresses, the edge-type
// selector codes, and a helper that picks the edge event for one bit.
// ---------------------------------------------------------------------------
package soc_pio_pkg;

    // Register word addresses (address[1:0])
    localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
    localparam logic [1:0] PIO_ADDR_RSVD    = 2'd1;
    localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

    // Edge types that can be captured
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // Returns the edge event for one bit. Any edge_type value that is not
    // rise or fall is treated as "any edge".
    function automatic logic edge_hit(input logic rise,
                                      input logic fall,
                                      input int   edge_type);
        logic hit;
        case (edge_type)
            EDGE_RISE: hit = rise;
            EDGE_FALL: hit = fall;
            default:   hit = rise | fall;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/pio_debounce_bit.sv
// ---------------------------------------------------------------------------
// pio_debounce_bit
// Synchronizes and debounces a single asynchronous input bit.
// A 2-FF synchronizer produces s. The debounced value db follows s only after
// s has differed from db for DEBOUNCE_CYCLES consecutive clocks. Any return
// to the current db value restarts the count.
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   raw      asynchronous external input bit
//   db       debounced, synchronous output bit
// ---------------------------------------------------------------------------
module pio_debounce_bit
    import soc_pio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic db
);

    logic meta;
    logic s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            s    <= 1'b0;
        end else begin
            meta <= raw;
            s    <= meta;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_no_debounce
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) db <= 1'b0;
                else          db <= s;
            end
        end else begin : g_debounce
            localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

            logic [CW-1:0] cnt;

            // The count reaches LAST on the DEBOUNCE_CYCLES-th differing
            // sample. The change is accepted on that same clock.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt <= '0;
                    db  <= 1'b0;
                end else if (s == db) begin
                    cnt <= '0;
                end else if (cnt == LAST) begin
                    db  <= s;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/soc_system_buttons_in.sv
// ---------------------------------------------------------------------------
// soc_system_buttons_in
// Avalon-MM input PIO with zero wait states. It debounces the keys and
// switches, latches the selected edges into EDGECAP, and raises a level
// interrupt when a captured edge is not masked.
// Register map:
//   0 DATA    (RO)  debounced input value
//   1 reserved      reads 0, writes ignored
//   2 IRQMASK (RW)
//   3 EDGECAP (W1C)
// Ports:
//   clk, reset_n                   clock, asynchronous active-low reset
//   address, chipselect, write_n   Avalon-MM slave control
//   writedata / readdata           32-bit data; only [WIDTH-1:0] is meaningful
//   in_port                        asynchronous external inputs
//   irq                            level interrupt |(edgecap & irqmask)
// ---------------------------------------------------------------------------
module soc_system_buttons_in
    import soc_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int EDGE_TYPE       = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] db;
    logic [WIDTH-1:0] db_prev;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecap;
    logic [WIDTH-1:0] cap_clear;
    logic             wr_en;

    assign wr_en = chipselect & ~write_n;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            pio_debounce_bit #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk    (clk),
                .reset_n(reset_n),
                .raw    (in_port[i]),
                .db     (db[i])
            );

            assign edge_det[i] = edge_hit(db[i] & ~db_prev[i],
                                          ~db[i] & db_prev[i],
                                          EDGE_TYPE);
        end

        // Only the low WIDTH bits of writedata are used.
        if (WIDTH < 32) begin : g_unused
            logic unused_wdata;
            assign unused_wdata = ^writedata[31:WIDTH];
        end
    endgenerate

    assign cap_clear = (wr_en && address == PIO_ADDR_EDGECAP) ?
                       writedata[WIDTH-1:0] : '0;

    // db_prev holds the previous debounced value. Both db_prev and db reset
    // to 0, so reset release cannot look like an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) db_prev <= '0;
        else          db_prev <= db;
    end

    // The clear is applied first and the new edge is OR-ed in afterwards.
    // A new edge therefore wins over a W1C of the same bit in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) edgecap <= '0;
        else          edgecap <= (edgecap & ~cap_clear) | edge_det;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask <= '0;
        end else if (wr_en && address == PIO_ADDR_IRQMASK) begin
            irqmask <= writedata[WIDTH-1:0];
        end
    end

    // The read mux does not look at chipselect, so readdata is always valid
    // and reads have no side effects.
    always_comb begin
        readdata = '0;
        case (address)
            PIO_ADDR_DATA:    readdata[WIDTH-1:0] = db;
            PIO_ADDR_IRQMASK: readdata[WIDTH-1:0] = irqmask;
            PIO_ADDR_EDGECAP: readdata[WIDTH-1:0] = edgecap;
            default:          readdata = '0;
        endcase
    end

    assign irq = |(edgecap & irqmask);

endmodule

// File: tb/tb_soc_system_buttons_in.sv
// ---------------------------------------------------------------------------
// tb_soc_system_buttons_in
// Self-checking bench for soc_system_buttons_in
// (WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_TYPE=falling).
// The bench runs a directed vector table, a few hand-written multi-cycle
// corner cases, and then a randomized phase. The randomized phase is checked
// against a sliding-window debounce model.
// ---------------------------------------------------------------------------
module tb_soc_system_buttons_in;

    localparam int W  = 4;
    localparam int D  = 4;
    localparam int ET = 1;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [W-1:0] in_port = '0;
    logic        irq;

    always #5 clk = ~clk;

    soc_system_buttons_in #(
        .WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(ET)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .irq       (irq)
    );

    int checks = 0;
    int errors = 0;

    // Reference model. The synchronizer is a 2-deep delay queue. A bit of db
    // flips when the last D synchronized samples all disagree with it.
    logic [W-1:0] m_db, m_db_prev, m_cap, m_mask;
    logic [W-1:0] dly[$];
    logic [W-1:0] win[$];

    typedef struct {
        logic [W-1:0] in_v;
        logic         cs;
        logic         wr_n;
        logic [1:0]   addr;
        logic [31:0]  wdata;
        logic [31:0]  exp_rd;
        logic         exp_irq;
    } vec_t;

    vec_t vecs[$];

    task automatic model_reset();
        m_db = '0; m_db_prev = '0; m_cap = '0; m_mask = '0;
        dly.delete(); dly.push_back('0); dly.push_back('0);
        win.delete();
        for (int k = 0; k < D; k++) win.push_back('0);
    endtask

    task automatic model_edge(input logic [W-1:0] inv, input logic cs,
                              input logic wr_n, input logic [1:0] addr,
                              input logic [31:0] wdata);
        logic [W-1:0] s_pre, new_db, rose, fell, edges, clr;
        logic all_diff;
        s_pre = dly.pop_front();
        dly.push_back(inv);
        win.push_back(s_pre);
        if (win.size() > D) void'(win.pop_front());
        new_db = m_db;
        for (int b = 0; b < W; b++) begin
            all_diff = 1'b1;
            foreach (win[j]) if (win[j][b] == m_db[b]) all_diff = 1'b0;
            if (all_diff) new_db[b] = ~m_db[b];
        end
        rose  = m_db & ~m_db_prev;
        fell  = ~m_db & m_db_prev;
        edges = (ET == 0) ? rose : (ET == 1) ? fell : (rose | fell);
        clr   = (cs && !wr_n && addr == 2'd3) ? wdata[W-1:0] : '0;
        m_cap = (m_cap & ~clr) | edges;
        if (cs && !wr_n && addr == 2'd2) m_mask = wdata[W-1:0];
        m_db_prev = m_db;
        m_db      = new_db;
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] addr);
        case (addr)
            2'd0:    return 32'(m_db);
            2'd2:    return 32'(m_mask);
            2'd3:    return 32'(m_cap);
            default: return 32'd0;
        endcase
    endfunction

    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drives one clock of inputs, keeps the model in step with the clock
    // edge, and leaves the outputs ready to sample 1 time unit after the edge.
    task automatic apply_stimulus(input logic [W-1:0] inv, input logic cs,
                                  input logic wr_n, input logic [1:0] addr,
                                  input logic [31:0] wdata);
        in_port = inv; chipselect = cs; write_n = wr_n;
        address = addr; writedata = wdata;
        @(posedge clk);
        model_edge(inv, cs, wr_n, addr, wdata);
        #1;
    endtask

    task automatic read_cycle(input logic [W-1:0] inv, input logic [1:0] addr);
        apply_stimulus(inv, 1'b0, 1'b1, addr, 32'd0);
    endtask

    // Asserts reset away from the clock edge. While reset is held, all four
    // addresses must read 0 and irq must be low.
    task automatic apply_reset();
        chipselect = 1'b0; write_n = 1'b1;
        reset_n = 1'b0;
        model_reset();
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            #1;
            check_output($sformatf("reset_rd_addr%0d", a), readdata, 32'd0);
        end
        check_output("reset_irq", 32'(irq), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic add_vec(input logic [W-1:0] inv, input logic cs,
                           input logic wr_n, input logic [1:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_rd,
                           input logic exp_irq);
        vec_t v;
        v.in_v = inv; v.cs = cs; v.wr_n = wr_n; v.addr = addr;
        v.wdata = wdata; v.exp_rd = exp_rd; v.exp_irq = exp_irq;
        vecs.push_back(v);
    endtask

    initial begin
        logic [W-1:0] rin;
        int hold;

        // Reset and power-up with all inputs high. Rising edges are not captured.
        apply_reset();
        for (int c = 0; c < 10; c++) read_cycle(4'hF, 2'd0);
        check_output("powerup_data", readdata, 32'h0000000F);
        read_cycle(4'hF, 2'd3);
        check_output("powerup_edgecap", readdata, 32'd0);

        // Vector table covering the bit0 fall, the bit1 glitch, and the mask/W1C irq sequence.
        for (int c = 0; c < 5; c++) add_vec(4'hE, 0, 1, 2'd0, 0, 32'hF, 0);
        add_vec(4'hE, 0, 1, 2'd0, 0, 32'hE, 0);
        add_vec(4'hE, 0, 1, 2'd3, 0, 32'h1, 0);
        add_vec(4'hE, 0, 1, 2'd0, 0, 32'hE, 0);
        add_vec(4'hE, 0, 1, 2'd3, 0, 32'h1, 0);
        add_vec(4'hE, 0, 1, 2'd3, 0, 32'h1, 0);
        for (int c = 0; c < 3; c++) add_vec(4'hC, 0, 1, 2'd0, 0, 32'hE, 0);
        for (int c = 0; c < 6; c++) add_vec(4'hE, 0, 1, 2'd0, 0, 32'hE, 0);
        add_vec(4'hE, 0, 1, 2'd3, 0, 32'h1, 0);
        add_vec(4'hE, 1, 0, 2'd2, 32'h1, 32'h1, 1);
        add_vec(4'hE, 1, 0, 2'd3, 32'h1, 32'h0, 0);
        add_vec(4'hE, 0, 1, 2'd3, 0, 32'h0, 0);
        add_vec(4'hE, 0, 1, 2'd2, 0, 32'h1, 0);
        add_vec(4'hE, 1, 0, 2'd1, 32'hF, 32'h0, 0);
        add_vec(4'hE, 0, 1, 2'd2, 0, 32'h1, 0);

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].in_v, vecs[i].cs, vecs[i].wr_n,
                           vecs[i].addr, vecs[i].wdata);
            check_output($sformatf("vec%0d_rd", i), readdata, vecs[i].exp_rd);
            check_output($sformatf("vec%0d_irq", i), 32'(irq), 32'(vecs[i].exp_irq));
        end

        // Bit2 falls. Its edge registers in the same cycle as a W1C of bit2, and the set must win.
        for (int c = 0; c < 6; c++) read_cycle(4'hA, 2'd3);
        check_output("w1c_race_before", readdata, 32'd0);
        apply_stimulus(4'hA, 1'b1, 1'b0, 2'd3, 32'h4);
        check_output("w1c_race_write", readdata, 32'h4);
        read_cycle(4'hA, 2'd3);
        check_output("w1c_race_after", readdata, 32'h4);
        check_output("w1c_race_irq", 32'(irq), 32'd0);
        read_cycle(4'hA, 2'd0);
        check_output("w1c_race_data", readdata, 32'hA);

        // Bit3 falls, and reset is asserted when its debounce count is 2.
        for (int c = 0; c < 4; c++) read_cycle(4'h2, 2'd0);
        check_output("middb_data", readdata, 32'hA);
        apply_reset();
        for (int c = 0; c < 5; c++) read_cycle(4'h2, 2'd0);
        check_output("postrst_data_early", readdata, 32'd0);
        read_cycle(4'h2, 2'd0);
        check_output("postrst_data", readdata, 32'h2);
        read_cycle(4'h2, 2'd3);
        read_cycle(4'h2, 2'd3);
        check_output("postrst_edgecap", readdata, 32'd0);
        check_output("postrst_irq", 32'(irq), 32'd0);

        // Randomized traffic checked against the reference model.
        apply_reset();
        rin = '0;
        hold = 0;
        for (int c = 0; c < 1500; c++) begin
            logic cs, wr_n;
            logic [1:0] addr;
            if (hold == 0) begin
                rin  = W'($urandom);
                hold = $urandom_range(1, 8);
            end
            hold--;
            cs   = ($urandom_range(0, 3) == 0);
            wr_n = $urandom_range(0, 1) == 1;
            addr = 2'($urandom);
            apply_stimulus(rin, cs, wr_n, addr, $urandom);
            check_output($sformatf("rand%0d_rd", c), readdata, model_read(addr));
            check_output($sformatf("rand%0d_irq", c), 32'(irq),
                         32'(|(m_cap & m_mask)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
